secded_data_collector: RTL and testbench
========================================

Name: secded_data_collector

Overview:
- Sits directly downstream of the SECDED decoder stage.
- Each cycle it can accept one corrected 13-bit codeword plus its decoder error flags over a valid/ready handshake.
- It extracts the 8 data bits and buffers them in a small FIFO for the consumer.
- It keeps saturating counts of corrected (1-bit) and uncorrectable (2-bit) words.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 8, width of each error counter
DROP_2BIT, 1, 1 = words flagged 2-bit are counted but not written to the FIFO; 0 = written with out_err2 set

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream word present
in_ready  output  1  block can accept a word this cycle
in_code  input  13  corrected codeword from the decoder; bit 0 global parity, bits 1/2/4/8 Hamming parity
in_is1BitErr  input  1  decoder corrected a single-bit error in in_code
in_is2BitErr  input  1  decoder detected an uncorrectable double error
out_valid  output  1  head FIFO entry present
out_ready  input  1  consumer takes the head entry
out_data  output  8  data byte of the head entry
out_err1  output  1  head entry was corrected
out_err2  output  1  head entry is uncorrectable (only possible when DROP_2BIT=0)
clear_counts  input  1  synchronous clear of both counters
count_1bit  output  CNT_W  saturating count of accepted 1-bit-error words
count_2bit  output  CNT_W  saturating count of accepted 2-bit-error words
fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset state:
  - FIFO empty; read and write pointers 0; fifo_count=0.
  - Both counters 0; out_valid=0.
  - out_data, out_err1 and out_err2 read 0 when empty.
  - in_ready=0 while reset is asserted.
  - Reset mid-operation discards all buffered entries on that edge.
- Handshake:
  - Accept when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = !reset && (fifo_count != DEPTH); it is a function of registered occupancy only.
  - When full, no accept occurs even if a pop happens in the same cycle.
- Data extraction: out byte d[7:0] = {cw[12],cw[11],cw[10],cw[9],cw[7],cw[6],cw[5],cw[3]}. Parity bits are ignored; no re-check is done here.
- Write rule per accepted word:
  - If in_is2BitErr && DROP_2BIT: no FIFO write.
  - Otherwise write {d, in_is1BitErr, in_is2BitErr}.
  - If both flags are set (illegal from the decoder), treat the word as a 2-bit error.
- Latency: FIFO is first-word fall-through. A word accepted at edge k gives out_valid=1 with its data in the cycle after edge k. Minimum latency 1 cycle; no combinational path from in_* to out_*.
- Simultaneous push and pop when non-empty and not full: occupancy is unchanged and both pointers advance.
- Empty: a pop is impossible because out_valid=0. A push into an empty FIFO is visible next cycle.
- Pointers wrap modulo DEPTH. Occupancy is held in a separate counter (full/empty are not inferred from pointer equality alone).
- Counters:
  - On accept, count_1bit increments if in_is1BitErr && !in_is2BitErr.
  - On accept, count_2bit increments if in_is2BitErr.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - clear_counts has priority: counters become 0 on that edge and a coincident increment is lost.
  - clear_counts does not affect the FIFO.

Decomposition:
- Package secded_pkg:
  - CW_W=13 and DATA_W=8.
  - DATA_POS constant array {3,5,6,7,9,10,11,12}.
  - Typedef fifo_entry_t struct {data[7:0], err1, err2}.
  - Function extract_data(cw) returning the data byte.
- Sub-module secded_fifo (parameter DEPTH, entry type fifo_entry_t): storage, pointers, occupancy and full/empty. The top level holds extraction, write-enable policy and counters.

Test Plan:
- Reset, then in_code=13'h1448, in_is1BitErr=0, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, out_err1=0, fifo_count=1; counters 0.
- Push 4 words (8'h01..8'h04) with out_ready=0 -> in_ready=0 after the 4th accept. A 5th word held valid is not taken. Then out_ready=1 for 1 cycle -> pops 8'h01, in_ready returns to 1, and the 5th word is accepted on the following edge.
- DROP_2BIT=1: word 13'h1448 with in_is2BitErr=1 -> fifo_count stays 0, count_2bit=1. With DROP_2BIT=0 the same stimulus gives out_data=8'hA5, out_err2=1.
- Continuous stream with in_valid=out_ready=1 for 10 words -> one word out per cycle, fifo_count constant at 1, order preserved across pointer wrap.
- CNT_W=2: 5 accepted 1-bit-error words -> count_1bit saturates at 3. Assert clear_counts together with a 6th 1-bit word -> count_1bit=0.
- Assert reset with 3 entries buffered -> next cycle out_valid=0, fifo_count=0, counters 0. After reset deasserts, in_ready=1.

Source files
------------

// File: rtl/secded_data_collector_pkg.sv
// Shared types and helpers for the SECDED data collector: codeword geometry,
// the buffered entry layout and the data-byte extraction function.
package secded_pkg;

    localparam int CW_W   = 13;
    localparam int DATA_W = 8;

    // Codeword bit positions holding data bits d[0]..d[7]; bit 0 and the powers of two are parity.
    localparam int DATA_POS [DATA_W] = '{32'd3, 32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd12};

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err1;
        logic              err2;
    } fifo_entry_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_data_collector_fifo.sv
// First-word-fall-through FIFO of fifo_entry_t with explicit occupancy counter;
// head data reads as zero while empty.
module secded_fifo
    import secded_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fifo_entry_t              wdata_i,
    output fifo_entry_t              rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           wr_en_s, rd_en_s;

    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign full_o  = (count_q == DEPTH[AW:0]);
    assign count_o = count_q;
    assign wr_en_s = push_i && !full_o;
    assign rd_en_s = pop_i && !empty_o;

    // Next-state for pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head entry, masked to zero while empty.
    always_comb begin
        if (empty_o) begin
            rdata_o = '0;
        end else begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/secded_data_collector.sv
// Collects corrected SECDED codewords, buffers their data bytes with error flags
// and keeps saturating counts of corrected and uncorrectable words.
module secded_data_collector
    import secded_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter bit DROP_2BIT = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW_W-1:0]          in_code,
    input  logic                     in_is1BitErr,
    input  logic                     in_is2BitErr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_err1,
    output logic                     out_err2,
    input  logic                     clear_counts,
    output logic [CNT_W-1:0]         count_1bit,
    output logic [CNT_W-1:0]         count_2bit,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic             accept_s, push_s, pop_s, inc1_s, inc2_s;
    logic             empty_s, full_s;
    fifo_entry_t      wentry_s, rentry_s;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    assign in_ready = !reset && !full_s;
    assign accept_s = in_valid && in_ready;
    // A word carrying both flags is treated as uncorrectable, so err1 is suppressed.
    assign inc1_s   = accept_s && in_is1BitErr && !in_is2BitErr;
    assign inc2_s   = accept_s && in_is2BitErr;
    assign push_s   = accept_s && !(in_is2BitErr && DROP_2BIT);
    assign pop_s    = out_valid && out_ready;

    assign wentry_s.data = extract_data(in_code);
    assign wentry_s.err1 = in_is1BitErr && !in_is2BitErr;
    assign wentry_s.err2 = in_is2BitErr;

    secded_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wentry_s),
        .rdata_o (rentry_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (fifo_count)
    );

    assign out_valid = !empty_s;
    assign out_data  = rentry_s.data;
    assign out_err1  = rentry_s.err1;
    assign out_err2  = rentry_s.err2;

    // Counter next-state: clear wins over a coincident increment; increments stop at all-ones.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (clear_counts) begin
            cnt1_d = {CNT_W{1'b0}};
            cnt2_d = {CNT_W{1'b0}};
        end else begin
            if (inc1_s && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1_d = cnt1_q;
            end
            if (inc2_s && (cnt2_q != {CNT_W{1'b1}})) begin
                cnt2_d = cnt2_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt2_d = cnt2_q;
            end
        end
    end

    // Error counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt1_q <= {CNT_W{1'b0}};
            cnt2_q <= {CNT_W{1'b0}};
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign count_1bit = cnt1_q;
    assign count_2bit = cnt2_q;

endmodule

// File: tb/tb_secded_data_collector.sv
// Directed self-checking bench: dut_a (DROP_2BIT=1, CNT_W=8) and dut_b
// (DROP_2BIT=0, CNT_W=2) share one stimulus stream.
module tb_secded_data_collector;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_is1BitErr, in_is2BitErr, out_ready, clear_counts;
    logic [12:0] in_code;

    logic       a_in_ready, a_out_valid, a_out_err1, a_out_err2;
    logic [7:0] a_out_data, a_c1, a_c2;
    logic [2:0] a_fcnt;
    logic       b_in_ready, b_out_valid, b_out_err1, b_out_err2;
    logic [7:0] b_out_data;
    logic [1:0] b_c1, b_c2;
    logic [2:0] b_fcnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    secded_data_collector #(.DEPTH(4), .CNT_W(8), .DROP_2BIT(1'b1)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_code(in_code), .in_is1BitErr(in_is1BitErr), .in_is2BitErr(in_is2BitErr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_err1(a_out_err1), .out_err2(a_out_err2), .clear_counts(clear_counts),
        .count_1bit(a_c1), .count_2bit(a_c2), .fifo_count(a_fcnt)
    );

    secded_data_collector #(.DEPTH(4), .CNT_W(2), .DROP_2BIT(1'b0)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_code(in_code), .in_is1BitErr(in_is1BitErr), .in_is2BitErr(in_is2BitErr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_err1(b_out_err1), .out_err2(b_out_err2), .clear_counts(clear_counts),
        .count_1bit(b_c1), .count_2bit(b_c2), .fifo_count(b_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Codeword with data byte d in positions 3,5,6,7,9,10,11,12; parity bits left 0.
    function automatic logic [12:0] place(input logic [7:0] d);
        logic [12:0] cw;
        cw = 13'h0000;
        cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
        cw[9] = d[4]; cw[10] = d[5]; cw[11] = d[6]; cw[12] = d[7];
        return cw;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_code = 13'h0000; in_is1BitErr = 1'b0;
        in_is2BitErr = 1'b0; out_ready = 1'b0; clear_counts = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_in_ready_a", a_in_ready, 1'b0);
        check("rst_in_ready_b", b_in_ready, 1'b0);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_fifo_count", a_fcnt, 3'd0);
        check("rst_out_data", a_out_data, 8'h00);
        check("rst_c1", a_c1, 8'd0);
        check("rst_c2", a_c2, 8'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", a_in_ready, 1'b1);

        // Single word, 1-cycle latency
        in_code = 13'h1448; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("w1_out_valid", a_out_valid, 1'b1);
        check("w1_out_data", a_out_data, 8'hA5);
        check("w1_out_err1", a_out_err1, 1'b0);
        check("w1_fifo_count", a_fcnt, 3'd1);
        check("w1_c1", a_c1, 8'd0);
        check("w1_c2", a_c2, 8'd0);
        do_reset();

        // Fill to full, hold a 5th word, then one pop
        for (int i = 1; i <= 4; i++) begin
            in_code = place(i[7:0]); in_valid = 1'b1;
            tick();
        end
        check("full_in_ready", a_in_ready, 1'b0);
        check("full_fifo_count", a_fcnt, 3'd4);
        in_code = place(8'h05);
        tick();
        check("full_hold_count", a_fcnt, 3'd4);
        check("full_head", a_out_data, 8'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_count", a_fcnt, 3'd3);
        check("pop_in_ready", a_in_ready, 1'b1);
        check("pop_head", a_out_data, 8'h02);
        tick();
        in_valid = 1'b0;
        check("w5_count", a_fcnt, 3'd4);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("drain_data", a_out_data, i);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", a_out_valid, 1'b0);
        check("drain_b_count", b_fcnt, 3'd0);

        // 2-bit word: dropped by dut_a, kept with err2 by dut_b
        in_code = 13'h1448; in_is2BitErr = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_is2BitErr = 1'b0;
        check("drop_a_count", a_fcnt, 3'd0);
        check("drop_a_valid", a_out_valid, 1'b0);
        check("drop_a_c2", a_c2, 8'd1);
        check("keep_b_valid", b_out_valid, 1'b1);
        check("keep_b_data", b_out_data, 8'hA5);
        check("keep_b_err2", b_out_err2, 1'b1);
        check("keep_b_err1", b_out_err1, 1'b0);
        check("keep_b_c2", b_c2, 2'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Both flags set behaves as a 2-bit error
        in_code = place(8'h3C); in_is1BitErr = 1'b1; in_is2BitErr = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_is1BitErr = 1'b0; in_is2BitErr = 1'b0;
        check("both_a_c1", a_c1, 8'd0);
        check("both_a_c2", a_c2, 8'd2);
        check("both_b_data", b_out_data, 8'h3C);
        check("both_b_err1", b_out_err1, 1'b0);
        check("both_b_err2", b_out_err2, 1'b1);
        check("both_b_c1", b_c1, 2'd0);
        do_reset();

        // Continuous stream across pointer wrap
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_code = place(8'h10 + i[7:0]);
            tick();
            check("stream_data", a_out_data, 8'h10 + i[7:0]);
            check("stream_count", a_fcnt, 3'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", a_out_valid, 1'b0);

        // Saturation on dut_b (CNT_W=2) and clear priority
        in_is1BitErr = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_code = place(8'h80 | i[7:0]);
            tick();
        end
        check("sat_b_c1", b_c1, 2'd3);
        check("sat_a_c1", a_c1, 8'd5);
        check("sat_head_err1", a_out_err1, 1'b1);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0; in_valid = 1'b0; in_is1BitErr = 1'b0;
        check("clr_b_c1", b_c1, 2'd0);
        check("clr_a_c1", a_c1, 8'd0);
        check("clr_fifo_kept", a_fcnt, 3'd1);
        tick();
        out_ready = 1'b0;

        // Reset with 3 buffered entries
        in_is1BitErr = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_code = place(8'h50 + i[7:0]);
            tick();
        end
        in_valid = 1'b0; in_is1BitErr = 1'b0;
        check("pre_rst_count", a_fcnt, 3'd3);
        check("pre_rst_c1", a_c1, 8'd3);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", a_out_valid, 1'b0);
        check("mid_rst_count", a_fcnt, 3'd0);
        check("mid_rst_c1", a_c1, 8'd0);
        check("mid_rst_b_c1", b_c1, 2'd0);
        check("mid_rst_in_ready", a_in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("after_rst_in_ready", a_in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
